// File: rtl/d_split_pkg.sv
// d_split shared types and constants.
// Lane FSM states, default comma bytes, pair bundle.
package d_split_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCK_A = 2'd2,
      LOCK_B = 2'd3
   } state_t;

   localparam logic [7:0] SYNC_1 = 8'hBC;
   localparam logic [7:0] SYNC_2 = 8'h3C;

   typedef struct packed {
      logic [7:0] lane1;
      logic [7:0] lane2;
   } pair_t;

endpackage

// File: rtl/d_split_pair_fifo.sv
// Pair FIFO for d_split: DEPTH entries of 2*DW bits.
// Flush wins over push/pop; push allowed when full if popping.
module pair_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [2*DW-1:0] wdata,
   output logic [2*DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   import d_split_pkg::*;

   logic [2*DW-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   count;
   logic            wr;
   logic            rd;

   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign rdata = mem[rd_ptr];

   assign rd = pop && !empty;
   assign wr = push && (!full || rd);

   // storage: cleared on reset so the head reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         if (wr && !rd) begin
            count <= count + 1'b1;
         end else if (rd && !wr) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/d_split.sv
// d_split: comma-locked splitter of an interleaved byte
// stream into lane-1/lane-2 pairs behind a valid/ready FIFO.
module d_split #(
   parameter int          DW     = 8,
   parameter int          DEPTH  = 4,
   parameter logic [DW-1:0] SYNC_1 = d_split_pkg::SYNC_1,
   parameter logic [DW-1:0] SYNC_2 = d_split_pkg::SYNC_2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DW-1:0]            in_data,
   input  logic                     realign,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data_1,
   output logic [DW-1:0]            out_data_2,
   output logic                     locked,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   import d_split_pkg::*;

   localparam int LW = $clog2(DEPTH) + 1;

   state_t          state;
   state_t          state_nx;
   logic [DW-1:0]   hold;
   logic            locked_q;
   logic            ovf_q;
   logic            pair_done;
   logic            is_comma;
   logic            push;
   logic            pop;
   logic            drop;
   logic            full;
   logic            empty;
   logic [2*DW-1:0] rdata;
   logic [LW-1:0]   fifo_level;

   assign pair_done = in_valid && !realign
                    && (state == LOCK_B);
   assign is_comma  = (hold == SYNC_1)
                    && (in_data == SYNC_2);
   assign push      = pair_done && !is_comma;
   assign pop       = out_ready && !empty;
   assign drop      = push && full && !pop;

   // lane phase search and lock sequencing
   always_comb begin
      state_nx = state;
      if (in_valid) begin
         unique case (state)
            HUNT: begin
               if (in_data == SYNC_1) state_nx = SYNC;
            end
            SYNC: begin
               if (in_data == SYNC_2) begin
                  state_nx = LOCK_A;
               end else if (in_data != SYNC_1) begin
                  state_nx = HUNT;
               end
            end
            LOCK_A:  state_nx = LOCK_B;
            LOCK_B:  state_nx = LOCK_A;
            default: state_nx = HUNT;
         endcase
      end
   end

   // state register; realign returns to hunting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HUNT;
      end else if (realign) begin
         state <= HUNT;
      end else begin
         state <= state_nx;
      end
   end

   // registered lock indication follows next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
      end else if (realign) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= (state_nx == LOCK_A)
                  || (state_nx == LOCK_B);
      end
   end

   // lane-1 byte held until its lane-2 partner arrives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (realign) begin
         hold <= '0;
      end else if (in_valid && state == LOCK_A) begin
         hold <= in_data;
      end
   end

   // sticky drop flag, cleared only by realign or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (realign) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end
   end

   pair_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (realign),
      .wdata ({hold, in_data}),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign out_valid  = !empty;
   assign out_data_1 = rdata[2*DW-1:DW];
   assign out_data_2 = rdata[DW-1:0];
   assign locked     = locked_q;
   assign level      = fifo_level;
   assign overflow   = ovf_q;

endmodule
